ntf_cic_decimator: RTL and testbench
====================================

# ntf_cic_decimator

Receive-side reconstruction block for the noise-shaped stream leaving the notch-filter modulator. It accepts signed WIDTH-bit NTF output codes at the modulator rate and applies a second-order CIC integrate/decimate/comb. It emits reconstructed 2*WIDTH-bit samples at 1/DECIM of the input rate over a valid/ready handshake. It sits between the noise-shaping loop and the measurement/monitor path, and lets the loop's transfer be checked end to end.

## Interface
- WIDTH, 16 (from lib_switchblock_pkg): input code width.
- DECIM, 8: decimation ratio; power of two, 2..64.
- clk_i  input  1  single clock.
- reset_i  input  1  synchronous, active-high reset.
- in_valid_i  input  1  input sample present.
- in_data_i  input  WIDTH  signed NTF code.
- in_ready_o  output  1  block can accept; transfer when in_valid_i && in_ready_o.
- out_valid_o  output  1  out_data_o holds an unconsumed sample.
- out_data_o  output  2*WIDTH  signed decimated sample, sign-extended.
- out_ready_i  input  1  consumer accepts; transfer when out_valid_o && out_ready_i.

## Operation
- Integrator width IW = WIDTH + 2*log2(DECIM). All integrator and comb arithmetic is two's-complement modulo 2^IW. Wrap is intentional; no saturation.
- On each accepted input:
  - i1_next = i1 + sext(in_data_i); i2_next = i2 + i1_next.
  - Register both values.
  - Increment phase counter 0..DECIM-1.
- On the accept with phase == DECIM-1 (window end):
  - c1 = i2_next - d1; y = c1 - d2.
  - d1 <= i2_next; d2 <= c1.
  - out_data_o <= sext(y); out_valid_o <= 1; phase <= 0.
- DC gain is DECIM^2. For a constant input x from reset, the outputs are 36x, 64x, 64x, … (DECIM=8).
- Output register holds one entry. out_valid_o clears on an output transfer, unless a new window-end accept happens on the same edge, in which case the new sample loads.
- in_ready_o = !(phase == DECIM-1 && out_valid_o && !out_ready_i). This is combinational from out_ready_i. Input stalls only when a window end would overwrite an unconsumed output, so no sample is ever lost.
- No accept means no state change, regardless of the other inputs.

## Timing
- Reset: i1, i2, d1, d2 = 0; phase = 0; out_valid_o = 0; out_data_o = 0. in_ready_o = 1 while in reset and on the first cycle after.
- Latency: out_valid_o rises on the clock edge that accepts the DECIM-th sample of a window. The sample is visible in the cycle after that accept.
- Throughput: one input per cycle when out_ready_i is held high. At most one output per DECIM accepted inputs.
- Simultaneous output transfer and window-end accept: the new sample replaces the old one and out_valid_o stays 1.
- Reset mid-window:
  - The partial window is discarded and a pending output is dropped.
  - Phase restarts at 0.
  - The next output needs DECIM fresh accepts.
- in_valid_i gaps stretch the window; phase counts accepts, not cycles.

## Structure
- lib_switchblock_pkg additions:
  - CIC_ORDER = 2.
  - DECIM_DEFAULT = 8.
  - Function clog2-based IW helper.
  - Typedef for the IW-wide signed accumulator.
- One sub-module, cic_integrator_stage: an IW-wide register with enable and synchronous clear. It is instantiated twice.
- Comb delays, phase counter and output register live in the top.

## Test plan
- Reset: hold reset_i for 3 cycles with in_valid_i = 1. Required: out_valid_o = 0, out_data_o = 0, in_ready_o = 1, and no state change.
- Constant in_data_i = 30 for 24 consecutive accepts with out_ready_i = 1. Required outputs: 1080, 1920, 1920, each one cycle after the 8th, 16th and 24th accept.
- Impulse at window start: 1000 at accept 0, then zeros, for 24 accepts. Required outputs: 8000, 0, 0.
- Impulse at window end: zeros, then 1000 at accept 7, then zeros, for 24 accepts. Required outputs: 1000, 7000, 0.
- Backpressure:
  - Constant 30, with out_ready_i = 0 after the first output.
  - Required: in_ready_o drops at the 16th accept attempt, and the first output (1080) is held.
  - Raise out_ready_i. Required: 1920 follows with no lost or duplicated input.
- Wrap and reset:
  - Constant -32768 for 40 accepts. Required steady output: -2097152, proving modular wrap is harmless.
  - Then assert reset_i at phase 3. Required: the next output after 8 accepts of 30 is 1080.

Source files
------------

// File: rtl/lib_switchblock_pkg.sv
// Shared constants and helpers for the switchblock receive path.
// Sizes the CIC accumulators so that wrap-around cancels exactly in the combs.
package lib_switchblock_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int DECIM_DEFAULT = 8;
  localparam int CIC_ORDER     = 2;

  // Bit growth of an N-stage CIC is N*log2(R); this width makes modular wrap harmless.
  function automatic int cic_iw(input int width, input int decim);
    return width + CIC_ORDER * $clog2(decim);
  endfunction

  localparam int IW_DEFAULT = cic_iw(WIDTH_DEFAULT, DECIM_DEFAULT);

  typedef logic signed [IW_DEFAULT-1:0] cic_acc_t;

endpackage

// File: rtl/ntf_cic_decimator_if.sv
// Input and output valid/ready channels of the NTF CIC decimator.
interface ntf_cic_decimator_if
  import lib_switchblock_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic                      in_valid_i;
  logic signed [WIDTH-1:0]   in_data_i;
  logic                      in_ready_o;
  logic                      out_valid_o;
  logic signed [2*WIDTH-1:0] out_data_o;
  logic                      out_ready_i;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );

endinterface

// File: rtl/ntf_cic_decimator_integrator.sv
// One CIC integrator register: loads d_i when enabled, clears synchronously.
module cic_integrator_stage #(
  parameter int IW = 22
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 en_i,
  input  logic signed [IW-1:0] d_i,
  output logic signed [IW-1:0] q_o
);

  logic signed [IW-1:0] acc_q;
  logic signed [IW-1:0] acc_d;

  always_comb begin
    acc_d = en_i ? d_i : acc_q;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  assign q_o = acc_q;

endmodule

// File: rtl/ntf_cic_decimator.sv
// Second-order CIC decimator: integrates NTF codes at the input rate, combs
// once per DECIM accepted samples and holds the result in a one-entry output.
module ntf_cic_decimator
  import lib_switchblock_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DECIM = DECIM_DEFAULT
) (
  input  logic                clk_i,
  input  logic                reset_i,
  ntf_cic_decimator_if.slave  bus
);

  localparam int IW = cic_iw(WIDTH, DECIM);
  localparam int PW = $clog2(DECIM);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);

  typedef logic signed [IW-1:0] acc_t;

  logic signed [WIDTH-1:0]   in_data;
  logic                      in_ready;
  logic                      accept;
  logic                      window_end;
  acc_t                      i1_q, i1_d, i2_q, i2_d;
  acc_t                      d1_q, d1_d, d2_q, d2_d;
  acc_t                      c1, y;
  logic [PW-1:0]             phase_q, phase_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [2*WIDTH-1:0] out_data_q, out_data_d;

  assign in_data = bus.in_data_i;

  // Stall only when this accept would overwrite an output nobody has taken yet.
  assign in_ready   = !(phase_q == PHASE_LAST && out_valid_q && !bus.out_ready_i);
  assign accept     = bus.in_valid_i && in_ready;
  assign window_end = accept && (phase_q == PHASE_LAST);

  always_comb begin
    i1_d = i1_q + acc_t'(in_data);
    i2_d = i2_q + i1_d;
    c1   = i2_d - d1_q;
    y    = c1 - d2_q;
  end

  cic_integrator_stage #(.IW(IW)) u_int1 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (accept),
    .d_i     (i1_d),
    .q_o     (i1_q)
  );

  cic_integrator_stage #(.IW(IW)) u_int2 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (accept),
    .d_i     (i2_d),
    .q_o     (i2_q)
  );

  always_comb begin
    phase_d     = phase_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_valid_q && bus.out_ready_i) out_valid_d = 1'b0;
    if (accept) phase_d = window_end ? '0 : phase_q + 1'b1;
    if (window_end) begin
      d1_d        = i2_d;
      d2_d        = c1;
      out_data_d  = (2*WIDTH)'(y);
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_q     <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      phase_q     <= phase_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;

endmodule

// File: tb/tb_ntf_cic_decimator.sv
// Scoreboard bench for ntf_cic_decimator: a convolution reference model predicts
// every decimated sample, a negedge monitor compares on each output transfer.
module tb_ntf_cic_decimator;
  import lib_switchblock_pkg::*;

  localparam int WIDTH = 16;
  localparam int DECIM = 8;

  logic clk = 1'b0;
  logic reset_i;

  ntf_cic_decimator_if #(.WIDTH(WIDTH)) bus ();

  ntf_cic_decimator #(.WIDTH(WIDTH), .DECIM(DECIM)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int     n_checks  = 0;
  int     n_fail    = 0;
  bit     rand_mode = 1'b0;
  longint hist[$];
  longint exp_q[$];
  longint got_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Decimated output = input history convolved with the triangular CIC kernel,
  // reduced to the accumulator width.
  function automatic longint cic_ref();
    longint acc = 0;
    int     n   = hist.size() - 1;
    for (int j = 0; j < 2*DECIM - 1; j++) begin
      longint h = (j < DECIM) ? longint'(j + 1) : longint'(2*DECIM - 1 - j);
      if (n - j >= 0) acc += h * hist[n-j];
    end
    return longint'(cic_acc_t'(acc));
  endfunction

  always @(negedge clk) begin
    if (reset_i) begin
      hist.delete();
      exp_q.delete();
    end else begin
      check("out_valid", longint'(bus.out_valid_o), longint'(exp_q.size() > 0));
      check("in_ready", longint'(bus.in_ready_o),
            longint'(!((hist.size() % DECIM) == DECIM-1 && exp_q.size() > 0 && !bus.out_ready_i)));
      if (bus.out_valid_o && bus.out_ready_i) begin
        got_q.push_back(longint'(bus.out_data_o));
        if (exp_q.size() == 0) fail_now("unexpected_output");
        else check("out_data", longint'(bus.out_data_o), exp_q.pop_front());
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        hist.push_back(longint'(bus.in_data_i));
        if (hist.size() % DECIM == 0) exp_q.push_back(cic_ref());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) bus.out_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input int val);
    int waited = 0;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = WIDTH'(val);
    forever begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        tick();
        break;
      end
      tick();
      waited++;
      if (waited > 200) begin
        fail_now("send_timeout");
        break;
      end
    end
    bus.in_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    bus.in_valid_i = 1'b0;
    reset_i = 1'b1;
    repeat (2) tick();
    reset_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready_i = 1'b1;
    while ((exp_q.size() != 0 || bus.out_valid_o) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) fail_now("drain_timeout");
    idle(1);
  endtask

  task automatic check_got(input string name, input int idx, input longint want);
    if (idx < got_q.size()) check(name, got_q[idx], want);
    else fail_now({name, "_missing"});
  endtask

  initial begin
    reset_i         = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i   = 16'sd1234;
    bus.out_ready_i = 1'b1;

    // Reset held with in_valid asserted: nothing may be absorbed.
    repeat (3) begin
      tick();
      @(negedge clk);
      check("rst_out_valid", longint'(bus.out_valid_o), 0);
      check("rst_out_data", longint'(bus.out_data_o), 0);
      check("rst_in_ready", longint'(bus.in_ready_o), 1);
    end
    #1;
    reset_i        = 1'b0;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", longint'(bus.in_ready_o), 1);
    tick();

    // Constant input straight out of reset.
    got_q.delete();
    repeat (24) send(30);
    drain();
    check("const_count", got_q.size(), 3);
    check_got("const_0", 0, 1080);
    check_got("const_1", 1, 1920);
    check_got("const_2", 2, 1920);

    // Impulse at window start.
    do_reset();
    got_q.delete();
    send(1000);
    repeat (23) send(0);
    drain();
    check("imp_start_count", got_q.size(), 3);
    check_got("imp_start_0", 0, 8000);
    check_got("imp_start_1", 1, 0);
    check_got("imp_start_2", 2, 0);

    // Impulse at window end.
    do_reset();
    got_q.delete();
    repeat (7) send(0);
    send(1000);
    repeat (16) send(0);
    drain();
    check("imp_end_count", got_q.size(), 3);
    check_got("imp_end_0", 0, 1000);
    check_got("imp_end_1", 1, 7000);
    check_got("imp_end_2", 2, 0);

    // Backpressure: first output held, 16th accept stalls until the consumer returns.
    do_reset();
    got_q.delete();
    repeat (8) send(30);
    bus.out_ready_i = 1'b0;
    repeat (7) send(30);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 16'sd30;
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready", longint'(bus.in_ready_o), 0);
      check("bp_hold_valid", longint'(bus.out_valid_o), 1);
      check("bp_hold_data", longint'(bus.out_data_o), 1080);
      tick();
    end
    bus.out_ready_i = 1'b1;
    send(30);
    drain();
    check("bp_count", got_q.size(), 2);
    check_got("bp_0", 0, 1080);
    check_got("bp_1", 1, 1920);

    // Full-scale negative input forces accumulator wrap.
    do_reset();
    got_q.delete();
    repeat (40) send(-32768);
    drain();
    check("wrap_count", got_q.size(), 5);
    check_got("wrap_0", 0, -1179648);
    for (int i = 1; i < 5; i++) check_got("wrap_steady", i, -2097152);

    // Reset in the middle of a window discards it.
    got_q.delete();
    repeat (3) send(30);
    do_reset();
    repeat (8) send(30);
    drain();
    check("midrst_count", got_q.size(), 1);
    check_got("midrst_0", 0, 1080);

    // Random data, input gaps and random consumer stalls.
    do_reset();
    got_q.delete();
    rand_mode = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      send(int'($urandom_range(0, 65535)) - 32768);
    end
    rand_mode = 1'b0;
    drain();
    check("rand_count", got_q.size(), 37);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
